// File: rtl/csa_accum_ctrl_if.sv
// rtl/csa_accum_ctrl_if.sv - operand/result handshake bundle for csa_accum_ctrl
//
// Purpose: groups the operand stream, result stream, abort and status lines
// of csa_accum_ctrl into one interface.
// Signals:
//   clr        producer -> ctrl   synchronous abort back to IDLE
//   in_valid   producer -> ctrl   operand valid
//   in_data    producer -> ctrl   W-bit unsigned operand
//   in_ready   ctrl -> producer   operand accepted when in_valid && in_ready
//   out_valid  ctrl -> consumer   result valid
//   out_sum    ctrl -> consumer   W+4-bit resolved sum
//   out_ready  consumer -> ctrl   result consumed when out_valid && out_ready
//   busy       ctrl -> any        high while accumulating or resolving
//   out_sat    ctrl -> consumer   result was clamped (CSA_SAT_EN builds only)
// Modports: master (producer/consumer side), slave (controller side).
// Macro: CSA_SAT_EN adds out_sat.

interface csa_accum_ctrl_if #(
   parameter int W = 8
);
   logic           clr;
   logic           in_valid;
   logic [W-1:0]   in_data;
   logic           in_ready;
   logic           out_valid;
   logic [W+3:0]   out_sum;
   logic           out_ready;
   logic           busy;
`ifdef CSA_SAT_EN
   logic           out_sat;

   modport master (
      output clr, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sum, busy, out_sat
   );

   modport slave (
      input  clr, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sum, busy, out_sat
   );
`else
   modport master (
      output clr, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sum, busy
   );

   modport slave (
      input  clr, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sum, busy
   );
`endif
endinterface

// File: rtl/csa_accum_ctrl.sv
// rtl/csa_accum_ctrl.sv - carry-save multi-operand accumulator with nibble-serial resolve
//
// Purpose: accepts CNT unsigned W-bit operands, compresses each one into a
// redundant sum/carry pair with a single 3:2 carry-save step, then resolves
// the pair four bits per cycle and presents the W+4-bit sum on a
// valid/ready result port.
// Ports:
//   i_clk    rising-edge clock
//   i_rst    asynchronous active-high reset
//   io_bus   csa_accum_ctrl_if.slave (clr, in_valid/in_data/in_ready,
//            out_valid/out_sum/out_ready, busy, out_sat when enabled)
// Parameters: W operand width (multiple of 4), CNT operands per sum (2..16).
// Macro: CSA_SAT_EN clamps results above 2^W-1 to 2^W-1 and flags out_sat.

module csa_accum_ctrl #(
   parameter int W   = 8,
   parameter int CNT = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   csa_accum_ctrl_if.slave    io_bus
);

   localparam int RW   = W + 4;
   localparam int NIBS = RW / 4;
   localparam int NW   = (NIBS > 1) ? $clog2(NIBS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCUM   = 2'd1,
      ST_RESOLVE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_next;

   logic [RW-1:0]   r_s;
   logic [RW-1:0]   r_c;
   logic [RW-1:0]   r_out_sum;
   logic [4:0]      r_cnt;
   logic [NW-1:0]   r_nib;
   logic            r_rc;
`ifdef CSA_SAT_EN
   logic            r_sat;
`endif

   logic            w_in_ready;
   logic            w_out_valid;
   logic            w_busy;
   logic            w_accept;
   logic            w_last_op;
   logic            w_last_nib;
   logic [RW-1:0]   w_op;
   logic [RW-1:0]   w_maj;
   logic [3:0]      w_s_nib;
   logic [3:0]      w_c_nib;
   logic [4:0]      w_nib_sum;
   logic [RW-1:0]   w_sum_next;

   // Acceptance is derived from the state register alone so it does not
   // loop through the FSM's combinational block. clr blocks acceptance even
   // though in_ready may still read 1 in that cycle.
   assign w_accept   = io_bus.in_valid && !io_bus.clr &&
                       ((r_state == ST_IDLE) || (r_state == ST_ACCUM));
   assign w_last_op  = (r_cnt == 5'(CNT - 1));
   assign w_last_nib = (r_nib == NW'(NIBS - 1));

   assign w_op  = {{(RW-W){1'b0}}, io_bus.in_data};
   assign w_maj = (r_s & r_c) | (r_s & w_op) | (r_c & w_op);

   // Select the nibble currently being resolved and splice its sum into the
   // running output word.
   always_comb begin
      w_s_nib    = '0;
      w_c_nib    = '0;
      w_sum_next = r_out_sum;
      for (int k = 0; k < NIBS; k++) begin
         if (r_nib == NW'(k)) begin
            w_s_nib = r_s[4*k +: 4];
            w_c_nib = r_c[4*k +: 4];
         end
      end
      w_nib_sum = {1'b0, w_s_nib} + {1'b0, w_c_nib} + {4'b0000, r_rc};
      for (int k = 0; k < NIBS; k++) begin
         if (r_nib == NW'(k)) begin
            w_sum_next[4*k +: 4] = w_nib_sum[3:0];
         end
      end
   end

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state and handshake outputs
   always_comb begin
      w_next      = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_busy      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_in_ready = 1'b1;
            if (w_accept) begin
               w_next = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            w_in_ready = 1'b1;
            w_busy     = 1'b1;
            if (w_accept && w_last_op) begin
               w_next = ST_RESOLVE;
            end
         end
         ST_RESOLVE: begin
            w_busy = 1'b1;
            if (w_last_nib) begin
               w_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_out_valid = 1'b1;
            if (io_bus.out_ready) begin
               w_next = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
      if (io_bus.clr) begin
         w_next = ST_IDLE;
      end
   end

   // Datapath registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s       <= '0;
         r_c       <= '0;
         r_out_sum <= '0;
         r_cnt     <= '0;
         r_nib     <= '0;
         r_rc      <= 1'b0;
`ifdef CSA_SAT_EN
         r_sat     <= 1'b0;
`endif
      end else if (io_bus.clr) begin
         // out_sum deliberately keeps its last value across an abort
         r_s   <= '0;
         r_c   <= '0;
         r_cnt <= '0;
         r_rc  <= 1'b0;
`ifdef CSA_SAT_EN
         r_sat <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_s   <= w_op;
                  r_c   <= '0;
                  r_cnt <= 5'd1;
               end
            end
            ST_ACCUM: begin
               if (w_accept) begin
                  // The carry's top bit is dropped; CNT*(2^W-1) < 2^RW
                  // guarantees it is always zero.
                  r_s   <= r_s ^ r_c ^ w_op;
                  r_c   <= {w_maj[RW-2:0], 1'b0};
                  r_cnt <= r_cnt + 5'd1;
                  if (w_last_op) begin
                     r_nib <= '0;
                     r_rc  <= 1'b0;
                  end
               end
            end
            ST_RESOLVE: begin
               r_rc  <= w_nib_sum[4];
               r_nib <= r_nib + NW'(1);
`ifdef CSA_SAT_EN
               if (w_last_nib && (|w_sum_next[RW-1:W])) begin
                  r_out_sum <= {{(RW-W){1'b0}}, {W{1'b1}}};
                  r_sat     <= 1'b1;
               end else begin
                  r_out_sum <= w_sum_next;
               end
`else
               r_out_sum <= w_sum_next;
`endif
            end
            ST_DONE: begin
`ifdef CSA_SAT_EN
               if (io_bus.out_ready) begin
                  r_sat <= 1'b0;
               end
`endif
            end
            default: begin
            end
         endcase
      end
   end

   assign io_bus.in_ready  = w_in_ready;
   assign io_bus.out_valid = w_out_valid;
   assign io_bus.out_sum   = r_out_sum;
   assign io_bus.busy      = w_busy;
`ifdef CSA_SAT_EN
   assign io_bus.out_sat   = r_sat;
`endif

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// tb/tb_csa_accum_ctrl.sv - self-checking bench for csa_accum_ctrl

module tb_csa_accum_ctrl;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   csa_accum_ctrl_if #(.W(8)) ifc4 ();
   csa_accum_ctrl_if #(.W(8)) ifc16 ();

   csa_accum_ctrl #(.W(8), .CNT(4)) u4 (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (ifc4.slave)
   );

   csa_accum_ctrl #(.W(8), .CNT(16)) u16 (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (ifc16.slave)
   );

   typedef struct packed {
      logic [3:0][7:0] ops;
      logic [11:0]     sum;
   } vec_t;

   vec_t vecs [8];
   int   n_total = 0;
   int   n_bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [11:0] model_sum(input logic [11:0] s);
`ifdef CSA_SAT_EN
      return (s > 12'd255) ? 12'd255 : s;
`else
      return s;
`endif
   endfunction

   task automatic send4(input logic [3:0][7:0] ops);
      for (int i = 0; i < 4; i++) begin
         ifc4.in_valid = 1'b1;
         ifc4.in_data  = ops[i];
         chk("in_ready_accum", 32'(ifc4.in_ready), 32'd1);
         tick();
      end
      ifc4.in_valid = 1'b0;
   endtask

   // Called one tick after the last accept edge; result should appear
   // three ticks later (three resolve nibbles).
   task automatic wait4(input string name, input logic [11:0] raw);
      int lat;
      lat = 0;
      while (!ifc4.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk({name, "_lat"}, 32'(lat), 32'd3);
      chk({name, "_sum"}, 32'(ifc4.out_sum), 32'(model_sum(raw)));
`ifdef CSA_SAT_EN
      chk({name, "_sat"}, 32'(ifc4.out_sat), 32'(raw > 12'd255));
`endif
   endtask

   task automatic consume4(input string name);
      ifc4.out_ready = 1'b1;
      tick();
      chk({name, "_vld_drop"}, 32'(ifc4.out_valid), 32'd0);
      chk({name, "_rdy_back"}, 32'(ifc4.in_ready), 32'd1);
   endtask

   initial begin
      int lat;
      vecs[0] = '{ops: {8'd4,   8'd3,   8'd2,   8'd1},   sum: 12'd10};
      vecs[1] = '{ops: {8'd255, 8'd255, 8'd255, 8'd255}, sum: 12'd1020};
      vecs[2] = '{ops: {8'd0,   8'd0,   8'd0,   8'd0},   sum: 12'd0};
      vecs[3] = '{ops: {8'd5,   8'd5,   8'd5,   8'd5},   sum: 12'd20};
      vecs[4] = '{ops: {8'd40,  8'd30,  8'd20,  8'd10},  sum: 12'd100};
      vecs[5] = '{ops: {8'd128, 8'd128, 8'd128, 8'd128}, sum: 12'd512};
      vecs[6] = '{ops: {8'd1,   8'd255, 8'd85,  8'd170}, sum: 12'd511};
      vecs[7] = '{ops: {8'd25,  8'd50,  8'd100, 8'd200}, sum: 12'd375};

      rst = 1'b1;
      ifc4.clr = 1'b0;   ifc4.in_valid = 1'b0;  ifc4.in_data = '0;  ifc4.out_ready = 1'b1;
      ifc16.clr = 1'b0;  ifc16.in_valid = 1'b0; ifc16.in_data = '0; ifc16.out_ready = 1'b1;
      #12;
      chk("rst_in_ready", 32'(ifc4.in_ready), 32'd1);
      chk("rst_out_valid", 32'(ifc4.out_valid), 32'd0);
      chk("rst_out_sum", 32'(ifc4.out_sum), 32'd0);
      chk("rst_busy", 32'(ifc4.busy), 32'd0);
`ifdef CSA_SAT_EN
      chk("rst_out_sat", 32'(ifc4.out_sat), 32'd0);
`endif
      #1 rst = 1'b0;
      tick();

      // Table-driven sums, result consumed immediately
      for (int v = 0; v < 8; v++) begin
         send4(vecs[v].ops);
         wait4($sformatf("vec%0d", v), vecs[v].sum);
         consume4($sformatf("vec%0d", v));
      end

      // Result held in DONE while out_ready is low; operand offered there is ignored
      ifc4.out_ready = 1'b0;
      send4({8'd4, 8'd3, 8'd2, 8'd1});
      wait4("hold", 12'd10);
      ifc4.in_valid = 1'b1;
      ifc4.in_data  = 8'd9;
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", 32'(ifc4.out_valid), 32'd1);
         chk("hold_sum", 32'(ifc4.out_sum), 32'd10);
         chk("hold_in_ready", 32'(ifc4.in_ready), 32'd0);
         chk("hold_busy", 32'(ifc4.busy), 32'd0);
         tick();
      end
      ifc4.out_ready = 1'b1;
      tick();
      chk("hold_hs_valid", 32'(ifc4.out_valid), 32'd0);
      chk("hold_hs_ready", 32'(ifc4.in_ready), 32'd1);
      chk("hold_hs_busy", 32'(ifc4.busy), 32'd0);
      ifc4.in_valid = 1'b0;
      send4({8'd1, 8'd1, 8'd1, 8'd9});
      wait4("after_hold", 12'd12);
      consume4("after_hold");

      // clr aborts a partial sum and blocks the operand offered with it
      ifc4.in_valid = 1'b1;
      ifc4.in_data  = 8'd7;
      tick();
      ifc4.in_data  = 8'd9;
      tick();
      ifc4.clr      = 1'b1;
      ifc4.in_data  = 8'd50;
      tick();
      ifc4.clr      = 1'b0;
      ifc4.in_valid = 1'b0;
      chk("clr_busy", 32'(ifc4.busy), 32'd0);
      chk("clr_in_ready", 32'(ifc4.in_ready), 32'd1);
      chk("clr_out_valid", 32'(ifc4.out_valid), 32'd0);
      send4({8'd40, 8'd30, 8'd20, 8'd10});
      wait4("after_clr", 12'd100);
      consume4("after_clr");

      // Asynchronous reset in the middle of RESOLVE
      send4({8'd4, 8'd3, 8'd2, 8'd1});
      tick();
      chk("mid_resolve_busy", 32'(ifc4.busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_in_ready", 32'(ifc4.in_ready), 32'd1);
      chk("arst_out_valid", 32'(ifc4.out_valid), 32'd0);
      chk("arst_out_sum", 32'(ifc4.out_sum), 32'd0);
      chk("arst_busy", 32'(ifc4.busy), 32'd0);
      #2 rst = 1'b0;
      tick();
      send4({8'd5, 8'd5, 8'd5, 8'd5});
      wait4("after_rst", 12'd20);
      consume4("after_rst");

      // CNT=16, all-ones operands: largest sum the carry register must hold
      for (int i = 0; i < 16; i++) begin
         ifc16.in_valid = 1'b1;
         ifc16.in_data  = 8'd255;
         chk("c16_in_ready", 32'(ifc16.in_ready), 32'd1);
         tick();
      end
      ifc16.in_valid = 1'b0;
      lat = 0;
      while (!ifc16.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk("c16_lat", 32'(lat), 32'd3);
      chk("c16_sum", 32'(ifc16.out_sum), 32'(model_sum(12'd4080)));
`ifdef CSA_SAT_EN
      chk("c16_sat", 32'(ifc16.out_sat), 32'd1);
`endif
      tick();
      chk("c16_vld_drop", 32'(ifc16.out_valid), 32'd0);
      chk("c16_rdy_back", 32'(ifc16.in_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
